// File: rtl/cadence_pkg.sv
// Shared types and constants for the cadence sensor emulator.
// Holds the FSM state type, LFSR taps/seed and the LFSR step function.
package cadence_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BOUNCE,
        STABLE
    } cad_state_t;

    localparam logic [15:0] CAD_LFSR_TAPS      = 16'hB400;
    localparam logic [15:0] CAD_LFSR_SEED_DFLT = 16'hACE1;

    // Fibonacci step for x^16+x^14+x^13+x^11+1, new bit enters at bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        return {q[14:0], ^(q & CAD_LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/cadence_if.sv
// Config and sensor-output bundle of cadence_gen.
// master = generator (drives the sensor lines), slave = consumer (drives config).
interface cadence_if #(
    parameter int HP_W = 24,
    parameter int BL_W = 16
);
    logic            en;
    logic [HP_W-1:0] half_period;
    logic [BL_W-1:0] bounce_len;
    logic            cadence;
    logic            cadence_gold;
    logic            edge_pulse;
    logic [7:0]      edge_cnt;

    modport master (
        input  en, half_period, bounce_len,
        output cadence, cadence_gold, edge_pulse, edge_cnt
    );

    modport slave (
        output en, half_period, bounce_len,
        input  cadence, cadence_gold, edge_pulse, edge_cnt
    );
endinterface

// File: rtl/lfsr16.sv
// 16-bit Fibonacci noise source; advances only when adv is high.
// Ports: clk, rst (sync, active high), adv, seed -> q.
module lfsr16
    import cadence_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        adv,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= seed;
        end else if (adv) begin
            q <= lfsr_step(q);
        end
    end

endmodule

// File: rtl/cadence_gen.sv
// Pedal-cadence sensor emulator: clean square wave plus a bouncy copy.
// Ports: clk, rst (sync, active high), bus (cadence_if.master).
module cadence_gen
    import cadence_pkg::*;
#(
    parameter int          HALF_PER_W = 24,
    parameter int          BOUNCE_W   = 16,
    parameter logic [15:0] LFSR_SEED  = CAD_LFSR_SEED_DFLT
) (
    input  logic      clk,
    input  logic      rst,
    cadence_if.master bus
);

    localparam int CNT_W = (HALF_PER_W > BOUNCE_W) ?
                           HALF_PER_W : BOUNCE_W;

    // An all-zero seed would lock the LFSR.
    localparam logic [15:0] SEED_EFF =
        (LFSR_SEED == 16'h0) ? 16'h0001 : LFSR_SEED;

    cad_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] hp_l, hp_l_n;
    logic [CNT_W-1:0] hp_in, bl_in;
    logic             gold, gold_n;
    logic             cad, cad_n;
    logic             pulse, pulse_n;
    logic [7:0]       ecnt, ecnt_n;
    logic [15:0]      lfsr_q;
    logic             adv;
    logic             toggle;

    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .adv  (adv),
        .seed (SEED_EFF),
        .q    (lfsr_q)
    );

    assign hp_in = (bus.half_period == '0) ?
                   CNT_W'(1) : CNT_W'(bus.half_period);
    assign bl_in = CNT_W'(bus.bounce_len);

    // Disable has priority over the STABLE expiry toggle.
    assign toggle = bus.en &&
                    ((state == IDLE) ||
                     (state == STABLE && cnt == CNT_W'(1)));

    assign adv = bus.en && (state == BOUNCE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            hp_l  <= CNT_W'(1);
            gold  <= 1'b0;
            cad   <= 1'b0;
            pulse <= 1'b0;
            ecnt  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            hp_l  <= hp_l_n;
            gold  <= gold_n;
            cad   <= cad_n;
            pulse <= pulse_n;
            ecnt  <= ecnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        hp_l_n  = hp_l;
        gold_n  = gold;
        cad_n   = cad;
        pulse_n = 1'b0;
        ecnt_n  = ecnt;
        if (!bus.en) begin
            state_n = IDLE;
            cad_n   = gold;
        end else if (toggle) begin
            gold_n  = ~gold;
            pulse_n = 1'b1;
            ecnt_n  = ecnt + 8'd1;
            hp_l_n  = hp_in;
            if (bl_in != '0) begin
                state_n = BOUNCE;
                cnt_n   = bl_in;
                cad_n   = lfsr_q[0];
            end else begin
                state_n = STABLE;
                cnt_n   = hp_in;
                cad_n   = ~gold;
            end
        end else begin
            unique case (state)
                BOUNCE: begin
                    if (cnt > CNT_W'(1)) begin
                        cad_n = lfsr_q[0];
                        cnt_n = cnt - CNT_W'(1);
                    end else begin
                        cad_n   = gold;
                        cnt_n   = hp_l;
                        state_n = STABLE;
                    end
                end
                STABLE: begin
                    cad_n = gold;
                    cnt_n = cnt - CNT_W'(1);
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    assign bus.cadence      = cad;
    assign bus.cadence_gold = gold;
    assign bus.edge_pulse   = pulse;
    assign bus.edge_cnt     = ecnt;

endmodule

// File: tb/tb_cadence_gen.sv
// Randomized self-checking bench for cadence_gen.
// Reference model tracks each gold level by age since its toggle.
module tb_cadence_gen;

    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [23:0] hp  = 24'd10;
    logic [15:0] bl  = 16'd0;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state
    bit          m_idle;
    int          m_age;
    int          m_hpl;
    int          m_bll;
    bit          m_gold;
    bit          m_cad;
    bit          m_pulse;
    int          m_ecnt;
    logic [15:0] m_lfsr;

    cadence_if #(.HP_W(24), .BL_W(16)) bus ();

    assign bus.en          = en;
    assign bus.half_period = hp;
    assign bus.bounce_len  = bl;

    cadence_gen #(
        .HALF_PER_W (24),
        .BOUNCE_W   (16),
        .LFSR_SEED  (SEED)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h",
                      tag, got, exp);
    endtask

    function automatic logic [15:0] poly_next(
        input logic [15:0] q);
        logic fb;
        fb = q[15] ^ q[13] ^ q[12] ^ q[10];
        return {q[14:0], fb};
    endfunction

    // One clock edge of the spec behaviour. A level lasts
    // bll+hpl clks; the first bll clks carry LFSR noise.
    task automatic model_edge();
        bit b;
        if (rst) begin
            m_idle = 1; m_age = 0; m_gold = 0; m_cad = 0;
            m_pulse = 0; m_ecnt = 0; m_lfsr = SEED;
        end else if (!en) begin
            m_idle = 1; m_cad = m_gold; m_pulse = 0;
        end else if (m_idle ||
                     m_age == m_bll + m_hpl - 1) begin
            m_gold  = !m_gold;
            m_pulse = 1;
            m_ecnt  = (m_ecnt + 1) % 256;
            m_hpl   = (hp == 0) ? 1 : int'(hp);
            m_bll   = int'(bl);
            m_age   = 0;
            m_idle  = 0;
            m_cad   = (m_bll > 0) ? m_lfsr[0] : m_gold;
        end else begin
            m_pulse = 0;
            b = m_lfsr[0];
            if (m_age < m_bll) m_lfsr = poly_next(m_lfsr);
            m_age++;
            m_cad = (m_age < m_bll) ? b : m_gold;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("cadence", 32'(bus.cadence), 32'(m_cad));
        chk("gold", 32'(bus.cadence_gold), 32'(m_gold));
        chk("pulse", 32'(bus.edge_pulse), 32'(m_pulse));
        chk("edge_cnt", 32'(bus.edge_cnt), 32'(m_ecnt));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // 1: reset held with en high
        rst = 1; en = 1; hp = 10; bl = 0;
        ticks(3);
        chk("rst_cad", 32'(bus.cadence), 0);
        chk("rst_gold", 32'(bus.cadence_gold), 0);
        chk("rst_ecnt", 32'(bus.edge_cnt), 0);
        rst = 0;
        tick();
        chk("first_pulse", 32'(bus.edge_pulse), 1);

        // 2: plain square wave, 40 clks total since reset
        ticks(39);
        chk("ecnt40", 32'(bus.edge_cnt), 4);

        // 4: disable on the cnt==1 edge, then mid-STABLE
        rst = 1; tick(); rst = 0;
        ticks(20);
        en = 0; tick();
        chk("no_toggle", 32'(bus.edge_cnt), 2);
        en = 1; tick();
        chk("reen_pulse", 32'(bus.edge_pulse), 1);
        ticks(3);
        en = 0; ticks(30);
        chk("frozen", 32'(bus.edge_cnt), 3);
        en = 1; ticks(25);

        // 3: bouncy levels
        hp = 20; bl = 5;
        ticks(130);

        // 5: reset in mid-bounce, pattern restarts from seed
        rst = 1; tick(); rst = 0;
        ticks(3);
        rst = 1; tick();
        chk("rst_bnc_cad", 32'(bus.cadence), 0);
        rst = 0;
        ticks(60);

        // random config, enable dropouts and resets
        for (int i = 0; i < 2500; i++) begin
            if (i % 80 == 0) begin
                hp = 24'($urandom_range(0, 12));
                bl = 16'($urandom_range(0, 6));
            end
            en  = ($urandom_range(0, 15) != 0);
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 0; en = 1;

        // 7: fastest toggle rate wraps edge_cnt
        hp = 0; bl = 0;
        rst = 1; tick(); rst = 0;
        ticks(256);
        chk("wrap", 32'(bus.edge_cnt), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
